// File: rtl/disp_pkg.sv
// Segment encoding constants and decoder FSM state type shared by the
// 7-segment scan encoder and the display-side decoder.
package disp_pkg;

  // Active-high segment patterns on seg[7:1] = {a,b,c,d,e,f,g}.
  localparam logic [6:0] SEG_0     = 7'h7E;
  localparam logic [6:0] SEG_1     = 7'h30;
  localparam logic [6:0] SEG_2     = 7'h6D;
  localparam logic [6:0] SEG_3     = 7'h79;
  localparam logic [6:0] SEG_4     = 7'h33;
  localparam logic [6:0] SEG_5     = 7'h5B;
  localparam logic [6:0] SEG_6     = 7'h5F;
  localparam logic [6:0] SEG_7     = 7'h70;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h7B;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [3:0] BLANK_CODE = 4'hF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    STALL = 2'd2
  } state_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational 7-segment pattern to digit decoder; unknown patterns are
// reported as blank with the illegal flag raised.
module seg7_decode
  import disp_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] value,
  output logic       illegal
);

  always_comb begin
    value   = BLANK_CODE;
    illegal = 1'b0;
    case (seg)
      SEG_0:     value = 4'd0;
      SEG_1:     value = 4'd1;
      SEG_2:     value = 4'd2;
      SEG_3:     value = 4'd3;
      SEG_4:     value = 4'd4;
      SEG_5:     value = 4'd5;
      SEG_6:     value = 4'd6;
      SEG_7:     value = 4'd7;
      SEG_8:     value = 4'd8;
      SEG_9:     value = 4'd9;
      SEG_BLANK: value = BLANK_CODE;
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/disp_scan_decode.sv
// Monitors a scanned, multiplexed 7-segment bus, captures each digit slot once
// it has settled, and publishes a full-frame snapshot when every slot was seen.
module disp_scan_decode
  import disp_pkg::*;
#(
  parameter int NDIG       = 8,
  parameter int STABLE_CYC = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        seg,
  input  logic [NDIG-1:0]   dig,
  output logic [4*NDIG-1:0] val,
  output logic [NDIG-1:0]   dp_out,
  output logic [NDIG-1:0]   err_out,
  output logic              frame_vld,
  output logic              bus_err,
  output logic              stalled
);

  localparam int SW = 8 + NDIG;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int CW = $clog2(NDIG + 1);
  localparam logic [3:0]    STABLE_MAX = 4'(STABLE_CYC);
  localparam logic [TW-1:0] TO_MAX     = TW'(TIMEOUT);

  logic [SW-1:0]     sample_reg, prev_reg;
  logic [3:0]        stab_reg, stab_next;
  logic [TW-1:0]     to_reg, to_next;
  logic              same, capture, valid_cap, multi_cap, to_expire, frame_done;
  logic [CW-1:0]     zero_cnt;
  logic [NDIG-1:0]   cap_dig, slot_we, seen_reg, seen_next, seen_merge;
  logic [3:0]        dec_value;
  logic              dec_illegal;
  logic [4*NDIG-1:0] live_val_reg, live_val_next;
  logic [NDIG-1:0]   live_dp_reg, live_dp_next, live_err_reg, live_err_next;
  state_t            state_reg, state_next;

  assign cap_dig = sample_reg[NDIG-1:0];
  assign same    = (sample_reg == prev_reg);

  // Capture exactly once, on the cycle the run length first reaches STABLE_CYC.
  always_comb begin
    stab_next = 4'd1;
    if (same)
      stab_next = (stab_reg == STABLE_MAX) ? stab_reg : stab_reg + 4'd1;
  end
  assign capture = (stab_next == STABLE_MAX) && ((stab_reg != STABLE_MAX) || !same);

  always_comb begin
    zero_cnt = '0;
    for (int i = 0; i < NDIG; i++)
      if (!cap_dig[i]) zero_cnt = zero_cnt + CW'(1);
  end
  assign valid_cap = capture && (zero_cnt == CW'(1));
  assign multi_cap = capture && (zero_cnt > CW'(1));

  seg7_decode u_dec (
    .seg     (sample_reg[SW-1:NDIG+1]),
    .value   (dec_value),
    .illegal (dec_illegal)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NDIG; gi = gi + 1) begin : g_slot
      assign slot_we[gi]              = valid_cap & ~cap_dig[gi];
      assign live_val_next[4*gi +: 4] = slot_we[gi] ? dec_value : live_val_reg[4*gi +: 4];
      assign live_dp_next[gi]         = slot_we[gi] ? sample_reg[NDIG] : live_dp_reg[gi];
      assign live_err_next[gi]        = slot_we[gi] ? dec_illegal : live_err_reg[gi];
    end
  endgenerate

  // A valid capture always wins over a coincident timeout expiry.
  assign to_next    = valid_cap ? '0 : ((to_reg == TO_MAX) ? to_reg : to_reg + TW'(1));
  assign to_expire  = !valid_cap && (to_next == TO_MAX);
  assign seen_merge = seen_reg | slot_we;
  assign frame_done = valid_cap && (&seen_merge);

  always_comb begin
    state_next = state_reg;
    seen_next  = seen_reg;
    case (state_reg)
      IDLE, SCAN: begin
        if (valid_cap) begin
          state_next = SCAN;
          seen_next  = frame_done ? '0 : seen_merge;
        end else if (to_expire) begin
          state_next = STALL;
          seen_next  = '0;
        end
      end
      STALL: begin
        if (valid_cap) begin
          state_next = SCAN;
          seen_next  = frame_done ? '0 : seen_merge;
        end
      end
      default: begin
        state_next = IDLE;
        seen_next  = '0;
      end
    endcase
  end

  assign stalled = (state_reg == STALL);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sample_reg   <= '0;
      prev_reg     <= '0;
      stab_reg     <= '0;
      to_reg       <= '0;
      state_reg    <= IDLE;
      seen_reg     <= '0;
      live_val_reg <= '0;
      live_dp_reg  <= '0;
      live_err_reg <= '0;
      val          <= '0;
      dp_out       <= '0;
      err_out      <= '0;
      frame_vld    <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      sample_reg   <= {seg, dig};
      prev_reg     <= sample_reg;
      stab_reg     <= stab_next;
      to_reg       <= to_next;
      state_reg    <= state_next;
      seen_reg     <= seen_next;
      live_val_reg <= live_val_next;
      live_dp_reg  <= live_dp_next;
      live_err_reg <= live_err_next;
      frame_vld    <= frame_done;
      bus_err      <= multi_cap;
      if (frame_done) begin
        val     <= live_val_next;
        dp_out  <= live_dp_next;
        err_out <= live_err_next;
      end
    end
  end

endmodule

// File: tb/tb_disp_scan_decode.sv
// Directed scan sequences for disp_scan_decode, checked every cycle against a
// run-length/frame behavioural model plus hand-computed frame expectations.
module tb_disp_scan_decode;

  localparam int NDIG = 8;
  localparam int STAB = 4;
  localparam int TMO  = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  seg = 8'h00;
  logic [7:0]  dig = 8'hFF;
  logic [31:0] val;
  logic [7:0]  dp_out, err_out;
  logic        frame_vld, bus_err, stalled;

  disp_scan_decode #(.NDIG(NDIG), .STABLE_CYC(STAB), .TIMEOUT(TMO)) dut (
    .clk       (clk),
    .rst       (rst),
    .seg       (seg),
    .dig       (dig),
    .val       (val),
    .dp_out    (dp_out),
    .err_out   (err_out),
    .frame_vld (frame_vld),
    .bus_err   (bus_err),
    .stalled   (stalled)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_frames = 0;
  int n_berr   = 0;

  // Full 8-bit seg patterns for digits 0..9 with dp clear.
  logic [7:0] pat [10] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hF6};

  // Model state.
  logic [31:0] exp_val;
  logic [7:0]  exp_dp, exp_err;
  logic        exp_vld, exp_berr, exp_stalled;
  logic [3:0]  live_v [8];
  logic [7:0]  live_dp, live_e, seen;
  logic [15:0] last_in;
  int          run, idle_cnt;
  logic        pend;
  logic [7:0]  pend_seg, pend_dig;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    exp_val = '0; exp_dp = '0; exp_err = '0;
    exp_vld = 1'b0; exp_berr = 1'b0; exp_stalled = 1'b0;
    for (int i = 0; i < 8; i++) live_v[i] = '0;
    live_dp = '0; live_e = '0; seen = '0;
    last_in = '0; run = 0; idle_cnt = 0;
    pend = 1'b0; pend_seg = '0; pend_dig = '0;
  endtask

  task automatic model_capture(input logic [7:0] s, input logic [7:0] d);
    int z, k;
    logic [3:0] v;
    logic e;
    z = 0; k = 0;
    for (int i = 0; i < 8; i++) if (!d[i]) begin z++; k = i; end
    if (z > 1) begin
      exp_berr = 1'b1;
    end else if (z == 1) begin
      v = 4'hF;
      e = (s[7:1] != 7'h00);
      for (int i = 0; i < 10; i++) if (s[7:1] == pat[i][7:1]) begin v = 4'(i); e = 1'b0; end
      live_v[k] = v; live_dp[k] = s[0]; live_e[k] = e;
      seen[k] = 1'b1;
      idle_cnt = 0;
      exp_stalled = 1'b0;
      if (seen == 8'hFF) begin
        for (int i = 0; i < 8; i++) exp_val[4*i +: 4] = live_v[i];
        exp_dp = live_dp; exp_err = live_e; exp_vld = 1'b1;
        seen = '0;
      end
    end
  endtask

  // One rising edge: a value that has been at the inputs for STAB edges takes
  // effect one edge later; time since the last slot capture drives the stall.
  task automatic model_step(input logic [7:0] s, input logic [7:0] d);
    logic do_cap;
    logic [7:0] cs, cd;
    do_cap = pend; cs = pend_seg; cd = pend_dig;
    exp_vld = 1'b0; exp_berr = 1'b0;
    if (idle_cnt < TMO) idle_cnt++;
    if (do_cap) model_capture(cs, cd);
    if (idle_cnt >= TMO && !exp_stalled) begin exp_stalled = 1'b1; seen = '0; end
    if ({s, d} == last_in) begin
      if (run < 1000) run++;
    end else begin
      run = 1;
    end
    last_in = {s, d};
    pend = (run == STAB); pend_seg = s; pend_dig = d;
  endtask

  task automatic step(input logic [7:0] s, input logic [7:0] d);
    seg = s; dig = d;
    @(posedge clk);
    model_step(s, d);
    @(negedge clk);
  endtask

  task automatic hold(input logic [7:0] s, input logic [7:0] d, input int n);
    $display("hold seg=%h dig=%h for %0d cycles", s, d, n);
    for (int i = 0; i < n; i++) step(s, d);
  endtask

  function automatic logic [7:0] sel(input int k);
    logic [7:0] r;
    r = 8'hFF;
    r[k] = 1'b0;
    return r;
  endfunction

  task automatic scan_slot(input int k, input logic [7:0] s);
    hold(s, sel(k), 6);
  endtask

  always @(negedge clk) begin
    check("val", val, exp_val);
    check("dp_out", 32'(dp_out), 32'(exp_dp));
    check("err_out", 32'(err_out), 32'(exp_err));
    check("frame_vld", 32'(frame_vld), 32'(exp_vld));
    check("bus_err", 32'(bus_err), 32'(exp_berr));
    check("stalled", 32'(stalled), 32'(exp_stalled));
    if (frame_vld) n_frames++;
    if (bus_err) n_berr++;
  end

  initial begin
    int f0, b0;
    #1 rst = 1'b0;
    #1;
    model_reset();
    check("rst_val", val, 32'h0);
    check("rst_flags", {24'h0, dp_out | err_out}, 32'h0);
    check("rst_pulses", {29'h0, frame_vld, bus_err, stalled}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Plain frame 0..7.
    f0 = n_frames;
    for (int k = 0; k < 8; k++) scan_slot(k, pat[k]);
    check("t1_frames", 32'(n_frames - f0), 32'd1);
    check("t1_val", val, 32'h76543210);
    check("t1_dp_err", {16'h0, dp_out, err_out}, 32'h0);

    // Decimal point on slot 3, illegal pattern on slot 2.
    f0 = n_frames;
    for (int k = 0; k < 8; k++)
      scan_slot(k, (k == 2) ? 8'h12 : ((k == 3) ? 8'hFF : pat[k]));
    check("t2_frames", 32'(n_frames - f0), 32'd1);
    check("t2_val", val, 32'h76548F10);
    check("t2_dp", 32'(dp_out), 32'h08);
    check("t2_err", 32'(err_out), 32'h04);

    // Three-cycle glitch on the frame-completing slot must not be captured.
    f0 = n_frames;
    for (int k = 0; k < 7; k++) scan_slot(k, pat[k]);
    hold(pat[9], sel(7), 3);
    check("t3_no_early", 32'(n_frames - f0), 32'd0);
    hold(pat[7], sel(7), 6);
    check("t3_frames", 32'(n_frames - f0), 32'd1);
    check("t3_val", val, 32'h76543210);

    // Multi-hot dig mid-frame: one bus_err, frame progress kept.
    f0 = n_frames; b0 = n_berr;
    for (int k = 0; k < 4; k++) scan_slot(k, pat[k]);
    hold(pat[8], 8'hF0, 5);
    for (int k = 4; k < 8; k++) scan_slot(k, pat[k]);
    check("t4_berr", 32'(n_berr - b0), 32'd1);
    check("t4_frames", 32'(n_frames - f0), 32'd1);
    check("t4_val", val, 32'h76543210);

    // Stall after partial scan; resume from slot 5 with fresh values.
    f0 = n_frames;
    for (int k = 0; k < 5; k++) scan_slot(k, pat[k]);
    hold(8'h00, 8'hFF, 64);
    check("t5_stalled", 32'(stalled), 32'd1);
    scan_slot(5, pat[4]);
    check("t5_resume", 32'(stalled), 32'd0);
    scan_slot(6, pat[3]);
    scan_slot(7, pat[2]);
    check("t5_no_early", 32'(n_frames - f0), 32'd0);
    for (int k = 0; k < 5; k++) scan_slot(k, pat[9-k]);
    check("t5_frames", 32'(n_frames - f0), 32'd1);
    check("t5_val", val, 32'h23456789);

    // Reset mid-frame, then a full rescan is needed.
    for (int k = 0; k < 6; k++) scan_slot(k, pat[k]);
    #2 rst = 1'b0;
    #1;
    check("t6_rst_val", val, 32'h0);
    check("t6_rst_flags", {24'h0, dp_out | err_out}, 32'h0);
    check("t6_rst_pulses", {29'h0, frame_vld, bus_err, stalled}, 32'h0);
    model_reset();
    seg = 8'h00; dig = 8'hFF;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    f0 = n_frames;
    scan_slot(6, pat[6]);
    scan_slot(7, pat[7]);
    check("t6_partial", 32'(n_frames - f0), 32'd0);
    for (int k = 0; k < 6; k++) scan_slot(k, pat[k]);
    check("t6_frames", 32'(n_frames - f0), 32'd1);
    check("t6_val", val, 32'h76543210);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
